// File: rtl/cnn_img_pkg.sv
// Shared constants and types for the CNN image capture path.
package cnn_img_pkg;

  localparam int unsigned DEF_PIC_SIZE = 32;
  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_ADDR_W   = 11;
  localparam int unsigned FRAME_PIXELS = DEF_PIC_SIZE * DEF_PIC_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } cap_state_t;

endpackage

// File: rtl/image_capture_if.sv
// Pixel-in, read-port and status bundle for image_capture.
interface image_capture_if
  import cnn_img_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic              cap_start;
  logic              pic_in_valid;
  logic [DATA_W-1:0] pic_in;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              frame_done;
  logic              overflow;
  logic [ADDR_W-1:0] wr_count;
  logic [DATA_W-1:0] checksum;

  modport master (
    output cap_start, pic_in_valid, pic_in, rd_en, rd_addr,
    input  rd_data, rd_valid, busy, frame_done, overflow, wr_count, checksum
  );

  modport slave (
    input  cap_start, pic_in_valid, pic_in, rd_en, rd_addr,
    output rd_data, rd_valid, busy, frame_done, overflow, wr_count, checksum
  );

endinterface

// File: rtl/image_buf.sv
// Simple dual-port frame RAM: one write port, one registered read port, read-before-write.
module image_buf #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // No reset on the array or read register so the tools map this onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/image_capture.sv
// Frame capture sink: writes one raster frame into image_buf and serves random reads.
// Optional build macro CAPTURE_CHECKSUM_EN adds a running modulo-2**DATA_W frame checksum.
module image_capture
  import cnn_img_pkg::*;
#(
  parameter int unsigned PIC_SIZE = DEF_PIC_SIZE,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input  logic            clk,
  input  logic            rst,
  image_capture_if.slave  bus
);

  localparam int unsigned       FrameLen = PIC_SIZE * PIC_SIZE;
  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(FrameLen - 1);
  localparam logic [ADDR_W:0]   FrameEnd = (ADDR_W + 1)'(FrameLen);

  cap_state_t        state_q;
  logic [ADDR_W-1:0] wr_count_q;
  logic              overflow_q;
  logic              frame_done_q;
  logic              rd_valid_q;
  logic              rd_oob_q;
  logic              wr_en;
  logic [DATA_W-1:0] ram_rdata;

  // cap_start wins over a same-cycle beat, so that beat is neither written nor an overflow.
  assign wr_en = (state_q == CAPTURE) && bus.pic_in_valid && !bus.cap_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_count_q   <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (bus.cap_start) begin
        state_q    <= CAPTURE;
        wr_count_q <= '0;
        overflow_q <= 1'b0;
      end else if (bus.pic_in_valid) begin
        if (state_q == CAPTURE) begin
          wr_count_q <= wr_count_q + 1'b1;
          if (wr_count_q == LastIdx) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
          end
        end else begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  // Out-of-frame reads are masked here; resetting the flag high also gives rd_data=0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b1;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_oob_q <= ({1'b0, bus.rd_addr} >= FrameEnd);
      end
    end
  end

  image_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_count_q),
    .wdata_i (bus.pic_in),
    .re_i    (bus.rd_en),
    .raddr_i (bus.rd_addr),
    .rdata_o (ram_rdata)
  );

`ifdef CAPTURE_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clk) begin
    if (rst || bus.cap_start) begin
      checksum_q <= '0;
    end else if (wr_en) begin
      checksum_q <= checksum_q + bus.pic_in;
    end
  end

  assign bus.checksum = checksum_q;
`else
  assign bus.checksum = '0;
`endif

  assign bus.rd_data    = rd_oob_q ? '0 : ram_rdata;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.busy       = (state_q == CAPTURE);
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;
  assign bus.wr_count   = wr_count_q;

endmodule

// File: tb/tb_image_capture.sv
// Directed-plus-random bench for image_capture against a frame-level reference model.
module tb_image_capture;
  import cnn_img_pkg::*;

  localparam int unsigned N = FRAME_PIXELS;
`ifdef CAPTURE_CHECKSUM_EN
  localparam logic [15:0] ExpCk1 = 16'hFE00;
`else
  localparam logic [15:0] ExpCk1 = 16'h0000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  image_capture_if bus ();

  image_capture dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int fd_seen = 0;

  // Reference model: frame-level view of the buffer and status.
  bit          m_cap;
  int          m_cnt;
  bit          m_ovf;
  logic [15:0] m_sum;
  logic [15:0] m_mem [N];
  bit          m_known [N];
  logic [15:0] exp_rd;
  bit          exp_known;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input bit fd, input bit rv);
    logic [15:0] exp_ck;
`ifdef CAPTURE_CHECKSUM_EN
    exp_ck = m_sum;
`else
    exp_ck = 16'h0;
`endif
    if (bus.frame_done === 1'b1) fd_seen++;
    chk("busy", 32'(bus.busy), 32'(m_cap));
    chk("wr_count", 32'(bus.wr_count), 32'(m_cnt));
    chk("frame_done", 32'(bus.frame_done), 32'(fd));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("rd_valid", 32'(bus.rd_valid), 32'(rv));
    if (exp_known) chk("rd_data", 32'(bus.rd_data), 32'(exp_rd));
    chk("checksum", 32'(bus.checksum), 32'(exp_ck));
  endtask

  task automatic cyc(input bit start, input bit valid, input logic [15:0] d,
                     input bit rden, input logic [10:0] ra);
    bit fd;
    fd = 1'b0;
    bus.cap_start    = start;
    bus.pic_in_valid = valid;
    bus.pic_in       = d;
    bus.rd_en        = rden;
    bus.rd_addr      = ra;
    // Read sees the buffer before this cycle's write.
    if (rden) begin
      if (int'(ra) >= N) begin
        exp_rd    = 16'h0;
        exp_known = 1'b1;
      end else begin
        exp_rd    = m_mem[ra];
        exp_known = m_known[ra];
      end
    end
    if (start) begin
      m_cap = 1'b1;
      m_cnt = 0;
      m_ovf = 1'b0;
      m_sum = 16'h0;
    end else if (valid) begin
      if (m_cap) begin
        m_mem[m_cnt]   = d;
        m_known[m_cnt] = 1'b1;
        m_sum          = m_sum + d;
        m_cnt++;
        if (m_cnt == N) begin
          m_cap = 1'b0;
          fd    = 1'b1;
        end
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_all(fd, rden);
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    bus.cap_start    = 1'b0;
    bus.pic_in_valid = 1'b1;
    bus.pic_in       = 16'h1234;
    bus.rd_en        = 1'b0;
    bus.rd_addr      = '0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    m_cap     = 1'b0;
    m_cnt     = 0;
    m_ovf     = 1'b0;
    m_sum     = 16'h0;
    exp_rd    = 16'h0;
    exp_known = 1'b1;
    for (int i = 0; i < int'(N); i++) m_known[i] = 1'b0;
    check_all(1'b0, 1'b0);
  endtask

  task automatic read_all();
    for (int a = 0; a <= int'(N); a++) cyc(1'b0, 1'b0, 16'h0, 1'b1, 11'(a));
  endtask

  initial begin
    bus.cap_start    = 1'b0;
    bus.pic_in_valid = 1'b0;
    bus.pic_in       = '0;
    bus.rd_en        = 1'b0;
    bus.rd_addr      = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Beats while idle raise overflow; cap_start clears it.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 16'($urandom), 1'b0, 11'd0);
    chk("ovf_idle", 32'(bus.overflow), 32'd1);
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 11'd0);
    chk("ovf_cleared", 32'(bus.overflow), 32'd0);

    // Frame 1: continuous beats, pic_in = index.
    fd_seen = 0;
    for (int i = 0; i < int'(N); i++) cyc(1'b0, 1'b1, 16'(i), 1'b0, 11'd0);
    chk("fd_at_last", 32'(bus.frame_done), 32'd1);
    chk("cksum_frame1", 32'(bus.checksum), 32'(ExpCk1));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 16'hFFFF, 1'b0, 11'd0);
    chk("ovf_done", 32'(bus.overflow), 32'd1);
    chk("fd_count1", 32'(fd_seen), 32'd1);
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 11'd0);
    chk("rd_a0", 32'(bus.rd_data), 32'd0);
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 11'd1);
    chk("rd_a1", 32'(bus.rd_data), 32'd1);
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 11'd1023);
    chk("rd_a1023", 32'(bus.rd_data), 32'd1023);
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 11'd1024);
    chk("rd_a1024", 32'(bus.rd_data), 32'd0);
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 11'd5);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 11'd9);
    chk("rd_hold", 32'(bus.rd_data), 32'd5);

    // Frame 2: valid toggling, same index data, random concurrent reads.
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 11'd0);
    fd_seen = 0;
    for (int i = 0; i < 3 * int'(N) && m_cnt < int'(N); i++) begin
      cyc(1'b0, bit'(i % 2), 16'(m_cnt), 1'($urandom_range(0, 1)),
          11'($urandom_range(0, 1100)));
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 16'h0, 1'b0, 11'd0);
    chk("wr_count2", 32'(bus.wr_count), 32'(N));
    chk("fd_count2", 32'(fd_seen), 32'd1);
    read_all();

    // Frame 3: restart after 500 random beats, then A5A5 frame with read-before-write probes.
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 11'd0);
    for (int i = 0; i < 500; i++) cyc(1'b0, 1'b1, 16'($urandom), 1'b0, 11'd0);
    fd_seen = 0;
    cyc(1'b1, 1'b1, 16'($urandom), 1'b0, 11'd0);
    chk("restart_count", 32'(bus.wr_count), 32'd0);
    for (int i = 0; i < int'(N); i++) cyc(1'b0, 1'b1, 16'hA5A5, 1'b1, 11'(m_cnt));
    chk("fd_count3", 32'(fd_seen), 32'd1);
    read_all();

    // Frame 4: reset at beat 300, then a full frame with random gaps.
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 11'd0);
    fd_seen = 0;
    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, 16'($urandom), 1'b0, 11'd0);
    do_reset();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_count", 32'(bus.wr_count), 32'd0);
    chk("fd_count_rst", 32'(fd_seen), 32'd0);
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 11'd0);
    for (int i = 0; i < 4 * int'(N) && m_cnt < int'(N); i++) begin
      cyc(1'b0, $urandom_range(0, 3) != 0, 16'($urandom), 1'b0, 11'd0);
    end
    chk("fd_count4", 32'(fd_seen), 32'd1);
    chk("wr_count4", 32'(bus.wr_count), 32'(N));
    read_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
